// File: rtl/jls_frame_ctrl.sv
// Frame sequencer for the regular-mode context coder: clears coder contexts, meters one frame, drains, signals done.
// Optional abort support is enabled by defining JLS_FRAME_ABORT_EN.
module jls_frame_ctrl #(
   parameter int unsigned W_BITS     = 16,
   parameter int unsigned CLR_CYCLES = 2,
   parameter int unsigned DRAIN_TO   = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [W_BITS-1:0] cfg_width,
   input  logic [W_BITS-1:0] cfg_height,
   output logic              busy,
   output logic              done,
   output logic              err_to,
`ifdef JLS_FRAME_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   input  logic              s_vl,
   output logic              s_rdy,
   input  logic [7:0]        s_x,
   input  logic [7:0]        s_px,
   input  logic              s_s,
   input  logic [4:0]        s_qh,
   output logic              c_rst,
   output logic              c_vl,
   output logic [7:0]        c_x,
   output logic [7:0]        c_px,
   output logic              c_s,
   output logic [4:0]        c_qh,
   input  logic              c_ovl
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_RUN, S_DRAIN, S_DONE, S_ABORT
   } state_t;

   state_t                state, next_state;
   logic                  rst_hold;
   logic [2*W_BITS-1:0]   total, in_cnt, out_cnt;
   logic [31:0]           clr_cnt, drain_cnt;
   logic                  xfer, accept, counting;

   assign xfer     = s_vl && s_rdy;
   assign accept   = (state == S_IDLE) && start;
   assign counting = (state == S_CLR) || (state == S_RUN) || (state == S_DRAIN);

   always_ff @(posedge clk) begin
      if (!rstn) state <= S_IDLE;
      else       state <= next_state;
   end

   // Keeps the coder in reset for one extra cycle after rstn is released.
   always_ff @(posedge clk) begin
      rst_hold <= ~rstn;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_CLR;
         S_CLR:   if (clr_cnt == CLR_CYCLES - 1)
                     next_state = (total == '0) ? S_DONE : S_RUN;
         S_RUN:   if (xfer && (in_cnt == total - 1'b1)) next_state = S_DRAIN;
         S_DRAIN: if ((out_cnt == total) || (drain_cnt == DRAIN_TO - 1)) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         S_ABORT: if (clr_cnt == CLR_CYCLES - 1) next_state = S_DONE;
         default: next_state = S_IDLE;
      endcase
`ifdef JLS_FRAME_ABORT_EN
      if (abort && counting) next_state = S_ABORT;
`endif
   end

   always_comb begin
      busy  = (state != S_IDLE);
      done  = (state == S_DONE);
      s_rdy = (state == S_RUN);
      c_rst = ~rstn | rst_hold | (state == S_CLR) | (state == S_ABORT);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         c_vl      <= 1'b0;
         c_x       <= '0;
         c_px      <= '0;
         c_s       <= 1'b0;
         c_qh      <= '0;
         err_to    <= 1'b0;
         total     <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         clr_cnt   <= '0;
         drain_cnt <= '0;
`ifdef JLS_FRAME_ABORT_EN
         aborted   <= 1'b0;
`endif
      end else begin
         c_vl <= xfer;
         if (xfer) begin
            c_x  <= s_x;
            c_px <= s_px;
            c_s  <= s_s;
            c_qh <= s_qh;
         end
         clr_cnt   <= (((state == S_CLR) || (state == S_ABORT)) && (next_state == state))
                      ? clr_cnt + 1'b1 : '0;
         drain_cnt <= ((state == S_DRAIN) && (next_state == S_DRAIN)) ? drain_cnt + 1'b1 : '0;
         if (accept) begin
            total   <= (2*W_BITS)'(cfg_width) * (2*W_BITS)'(cfg_height);
            in_cnt  <= '0;
            out_cnt <= '0;
            err_to  <= 1'b0;
`ifdef JLS_FRAME_ABORT_EN
            aborted <= 1'b0;
`endif
         end else begin
            if (xfer) in_cnt <= in_cnt + 1'b1;
            if (c_ovl && counting && (out_cnt != total)) out_cnt <= out_cnt + 1'b1;
            // Leaving DRAIN without every coded pixel seen means the watchdog fired.
            if ((state == S_DRAIN) && (next_state == S_DONE) && (out_cnt != total))
               err_to <= 1'b1;
`ifdef JLS_FRAME_ABORT_EN
            if ((next_state == S_ABORT) && (state != S_ABORT)) aborted <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_jls_frame_ctrl.sv
// Directed bench for jls_frame_ctrl with an 11-cycle coder latency model.
module tb_jls_frame_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_width = '0, cfg_height = '0;
   logic        busy, done, err_to;
   logic        s_vl = 1'b0, s_rdy;
   logic [7:0]  s_x = 8'hA5, s_px = 8'h3C;
   logic        s_s = 1'b1;
   logic [4:0]  s_qh = 5'd17;
   logic        c_rst, c_vl, c_s, c_ovl;
   logic [7:0]  c_x, c_px;
   logic [4:0]  c_qh;
`ifdef JLS_FRAME_ABORT_EN
   logic        abort = 1'b0, aborted;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cvl_cnt = 0, done_cnt = 0, crst_cnt = 0, xfer_cnt = 0;
   logic        ovl_en = 1'b1;
   logic [10:0] pipe;

   jls_frame_ctrl #(.W_BITS(16), .CLR_CYCLES(2), .DRAIN_TO(32)) dut (
      .clk(clk), .rstn(rstn), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .busy(busy), .done(done), .err_to(err_to),
`ifdef JLS_FRAME_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .s_vl(s_vl), .s_rdy(s_rdy), .s_x(s_x), .s_px(s_px), .s_s(s_s), .s_qh(s_qh),
      .c_rst(c_rst), .c_vl(c_vl), .c_x(c_x), .c_px(c_px), .c_s(c_s), .c_qh(c_qh),
      .c_ovl(c_ovl)
   );

   always #5 clk = ~clk;

   // Coder: one o_vl per input pixel, 11 cycles later; flushed by its reset.
   always @(posedge clk) begin
      if (c_rst) pipe <= '0;
      else       pipe <= {pipe[9:0], c_vl & ovl_en};
   end
   assign c_ovl = pipe[10];

   always @(negedge clk) begin
      cvl_cnt  += int'(c_vl);
      done_cnt += int'(done);
      crst_cnt += int'(c_rst);
      xfer_cnt += int'(s_vl & s_rdy);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
      @(posedge clk); #1;
      cfg_width = w; cfg_height = h; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc, output int n);
      logic found;
      found = 1'b0;
      n = 0;
      while (n < max_cyc && !found) begin
         @(negedge clk);
         n++;
         if (done) found = 1'b1;
      end
      check(tag, found, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench hung");
   end

   initial begin
      int n, b_cvl, b_done, b_crst, b_xfer;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err_to, 1'b0);
      check("rst_srdy", s_rdy, 1'b0);
      check("rst_cvl", c_vl, 1'b0);
      check("rst_crst", c_rst, 1'b1);
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      check("rst_crst_hold", c_rst, 1'b1);
      @(negedge clk);
      check("rst_crst_rel", c_rst, 1'b0);

      // 1: 4x2 frame, coder loops back.
      s_vl = 1'b1;
      b_cvl = cvl_cnt; b_done = done_cnt; b_xfer = xfer_cnt;
      start_frame(16'd4, 16'd2);
      wait_done("t1_done", 200, n);
      check("t1_latency", n, 24);
      check("t1_err", err_to, 1'b0);
      @(negedge clk);
      check("t1_cvl_cnt", cvl_cnt - b_cvl, 8);
      check("t1_xfer_cnt", xfer_cnt - b_xfer, 8);
      check("t1_done_cnt", done_cnt - b_done, 1);
      check("t1_cx", c_x, 8'hA5);
      check("t1_cpx", c_px, 8'h3C);
      check("t1_cs", c_s, 1'b1);
      check("t1_cqh", c_qh, 5'd17);
      check("t1_cvl_idle", c_vl, 1'b0);

      // 2: empty frame.
      b_cvl = cvl_cnt; b_crst = crst_cnt;
      start_frame(16'd0, 16'd5);
      wait_done("t2_done", 50, n);
      check("t2_latency", n, 3);
      @(negedge clk);
      check("t2_done_pulse", done, 1'b0);
      check("t2_busy", busy, 1'b0);
      check("t2_crst_cnt", crst_cnt - b_crst, 2);
      check("t2_cvl_cnt", cvl_cnt - b_cvl, 0);

      // 3: coder silent, drain watchdog expires.
      ovl_en = 1'b0;
      start_frame(16'd3, 16'd1);
      wait_done("t3_done", 100, n);
      check("t3_latency", n, 38);
      check("t3_err", err_to, 1'b1);
      repeat (2) @(negedge clk);
      check("t3_err_sticky", err_to, 1'b1);
      ovl_en = 1'b1;

      // 4: reset mid-RUN after 5 pixels.
      b_xfer = xfer_cnt; b_done = done_cnt;
      start_frame(16'd4, 16'd4);
      @(negedge clk);
      check("t4_err_clr", err_to, 1'b0);
      repeat (7) @(posedge clk);
      #1 rstn = 1'b0;
      check("t4_xfer5", xfer_cnt - b_xfer, 5);
      b_crst = crst_cnt;
      @(posedge clk); #1 rstn = 1'b1;
      repeat (4) @(negedge clk);
      check("t4_busy", busy, 1'b0);
      check("t4_crst_cnt", crst_cnt - b_crst, 2);
      check("t4_no_done", done_cnt - b_done, 0);

      // 5: start ignored outside IDLE, cfg changes ignored.
      b_cvl = cvl_cnt; b_done = done_cnt;
      start_frame(16'd2, 16'd2);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; cfg_width = 16'd7; cfg_height = 16'd7;
      @(posedge clk); #1 start = 1'b0; cfg_width = 16'd9; cfg_height = 16'd9;
      wait_done("t5_done", 100, n);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_busy", busy, 1'b0);
      check("t5_cvl_cnt", cvl_cnt - b_cvl, 4);
      check("t5_done_cnt", done_cnt - b_done, 1);

`ifdef JLS_FRAME_ABORT_EN
      // 6: abort after 3 of 16 pixels.
      b_crst = crst_cnt;
      start_frame(16'd4, 16'd4);
      repeat (5) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      check("t6_srdy", s_rdy, 1'b0);
      wait_done("t6_done", 20, n);
      check("t6_aborted", aborted, 1'b1);
      check("t6_crst_cnt", crst_cnt - b_crst, 4);
`endif

      s_vl = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
